// File: rtl/fir_accumulator_if.sv
// Product stream into the FIR accumulator and the filtered sample stream out of it.
// The master drives products and control; the slave (the accumulator) returns samples and status.
interface fir_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int TAPS   = 8
);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic              enable;
  logic              clear;
  logic [DATA_W-1:0] prod_in;
  logic              prod_valid;
  logic [DATA_W-1:0] acc_out;
  logic              acc_valid;
  logic [CNT_W-1:0]  tap_count;
  logic              overflow;

  modport master (
    output enable, clear, prod_in, prod_valid,
    input  acc_out, acc_valid, tap_count, overflow
  );

  modport slave (
    input  enable, clear, prod_in, prod_valid,
    output acc_out, acc_valid, tap_count, overflow
  );
endinterface

// File: rtl/fir_accumulator.sv
// Sums TAPS signed products into one shifted, saturated sample; output registered on the edge taking the last product.
// No backpressure: every product accepted while enabled is consumed; enable=0 freezes all state.
module fir_accumulator #(
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 40,
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  fir_accumulator_if.slave  bus
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc_out;
  logic              r_acc_vld;
  logic              r_ovf;

  logic [ACC_W:0]         w_sum_wide;
  logic                   w_acc_ovf;
  logic [ACC_W-1:0]       w_acc_clamped;
  logic signed [ACC_W-1:0] w_shifted;
  logic [ACC_W-DATA_W:0]  w_upper;
  logic                   w_out_ovf;
  logic [DATA_W-1:0]      w_out_sat;
  logic                   w_last;

  // One guard bit above the accumulator exposes signed overflow of the add.
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-DATA_W){bus.prod_in[DATA_W-1]}}, bus.prod_in};
  assign w_acc_ovf  = w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1];

  always_comb begin
    w_acc_clamped = w_sum_wide[ACC_W-1:0];
    if (w_acc_ovf) begin
      w_acc_clamped = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign w_shifted = $signed(w_acc_clamped) >>> OUT_SHIFT;

  // Sample fits in DATA_W only when every bit from the output sign bit upward agrees.
  assign w_upper   = w_shifted[ACC_W-1:DATA_W-1];
  assign w_out_ovf = !((&w_upper) || !(|w_upper));

  always_comb begin
    w_out_sat = w_shifted[DATA_W-1:0];
    if (w_out_ovf) begin
      w_out_sat = w_shifted[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_acc_out <= '0;
      r_acc_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (bus.enable) begin
      r_acc_vld <= 1'b0;
      if (bus.clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (bus.prod_valid) begin
        if (w_last) begin
          r_acc_out <= w_out_sat;
          r_acc_vld <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          if (w_acc_ovf || w_out_ovf) begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_acc <= w_acc_clamped;
          r_cnt <= r_cnt + 1'b1;
          if (w_acc_ovf) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end else begin
      r_acc_vld <= 1'b0;
    end
  end

  assign bus.acc_out   = r_acc_out;
  assign bus.acc_valid = r_acc_vld;
  assign bus.tap_count = r_cnt;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_fir_accumulator.sv
// Randomised and directed checks of fir_accumulator against a frame-level reference model.
module tb_fir_accumulator;
  localparam int  DATA_W    = 32;
  localparam int  ACC_W     = 40;
  localparam int  TAPS      = 4;
  localparam int  OUT_SHIFT = 0;
  localparam longint ACC_HI = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_LO = -(64'sd1 <<< (ACC_W - 1));
  localparam longint OUT_HI = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint OUT_LO = -(64'sd1 <<< (DATA_W - 1));

  logic clk;
  logic reset;

  fir_accumulator_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus ();

  fir_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: products of the open frame plus the registered outputs.
  longint      m_frame[$];
  logic [31:0] m_out;
  logic        m_vld;
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_out = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic clr, input logic pv, input logic [31:0] pin);
    longint s;
    m_vld = 1'b0;
    if (!en) return;
    if (clr) begin
      m_frame.delete();
    end else if (pv) begin
      m_frame.push_back(longint'($signed(pin)));
      if (m_frame.size() == TAPS) begin
        s = 0;
        foreach (m_frame[i]) begin
          s += m_frame[i];
          if (s > ACC_HI) begin s = ACC_HI; m_ovf = 1'b1; end
          if (s < ACC_LO) begin s = ACC_LO; m_ovf = 1'b1; end
        end
        s = s >>> OUT_SHIFT;
        if (s > OUT_HI) begin s = OUT_HI; m_ovf = 1'b1; end
        if (s < OUT_LO) begin s = OUT_LO; m_ovf = 1'b1; end
        m_out = 32'(s);
        m_vld = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".acc_out"},   64'(bus.acc_out),   64'(m_out));
    check({tag, ".acc_valid"}, 64'(bus.acc_valid), 64'(m_vld));
    check({tag, ".tap_count"}, 64'(bus.tap_count), 64'(m_frame.size()));
    check({tag, ".overflow"},  64'(bus.overflow),  64'(m_ovf));
  endtask

  task automatic step(input string tag, input logic en, input logic clr, input logic pv,
                      input logic [31:0] pin);
    bus.enable     = en;
    bus.clear      = clr;
    bus.prod_valid = pv;
    bus.prod_in    = pin;
    @(posedge clk);
    model_edge(en, clr, pv, pin);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic prod(input string tag, input logic [31:0] pin);
    step(tag, 1'b1, 1'b0, 1'b1, pin);
  endtask

  task automatic randomize_inputs();
    bus.enable     = 1'($urandom);
    bus.clear      = 1'($urandom);
    bus.prod_valid = 1'($urandom);
    bus.prod_in    = $urandom;
  endtask

  // Asserts reset between edges, checks the immediate clear, then releases on a falling edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    randomize_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] rp;
  logic [31:0] mx_d1, mx_d2;
  logic        mv_d1, mv_d2;

  initial begin
    reset = 1'b0;
    randomize_inputs();
    model_reset();
    repeat (3) begin
      randomize_inputs();
      @(posedge clk);
      @(negedge clk);
      check_outputs("rst_hold");
    end
    reset = 1'b1;

    prod("f1", 32'd1);
    check("f1.tap1", 64'(bus.tap_count), 64'd1);
    prod("f1", 32'd2);
    prod("f1", 32'd3);
    prod("f1", 32'd4);
    check("sum10", 64'(bus.acc_out), 64'd10);
    check("sum10.vld", 64'(bus.acc_valid), 64'd1);
    check("sum10.tap", 64'(bus.tap_count), 64'd0);
    for (int i = 5; i <= 8; i++) prod("f2", 32'(i));
    check("sum26", 64'(bus.acc_out), 64'd26);

    prod("stall", 32'd5);
    step("stall", 1'b1, 1'b0, 1'b0, 32'd77);
    prod("stall", 32'd5);
    step("stall", 1'b0, 1'b0, 1'b1, 32'd100);
    check("stall.novld", 64'(bus.acc_valid), 64'd0);
    step("stall", 1'b0, 1'b0, 1'b1, 32'd100);
    prod("stall", 32'd5);
    prod("stall", 32'd5);
    check("sum20", 64'(bus.acc_out), 64'd20);

    repeat (4) prod("neg", 32'hFFFF_FFFD);
    check("neg3", 64'(bus.acc_out), 64'hFFFF_FFF4);
    check("neg3.ovf", 64'(bus.overflow), 64'd0);

    repeat (4) prod("sat", 32'h7FFF_FFFF);
    check("sat.max", 64'(bus.acc_out), 64'h7FFF_FFFF);
    check("sat.ovf", 64'(bus.overflow), 64'd1);
    repeat (4) prod("sticky", 32'd1);
    check("sticky.sum", 64'(bus.acc_out), 64'd4);
    check("sticky.ovf", 64'(bus.overflow), 64'd1);

    prod("clr", 32'd9);
    prod("clr", 32'd9);
    step("clr", 1'b1, 1'b1, 1'b1, 32'd50);
    check("clr.tap", 64'(bus.tap_count), 64'd0);
    repeat (4) prod("clr", 32'd1);
    check("clr.sum4", 64'(bus.acc_out), 64'd4);

    prod("rstmid", 32'd9);
    prod("rstmid", 32'd9);
    async_reset("rst_async");
    repeat (4) prod("rstmid", 32'd1);
    check("rstmid.sum4", 64'(bus.acc_out), 64'd4);

    // Two-cycle multiplier stand-in: squares of x appear two cycles after x is presented.
    mx_d1 = '0; mx_d2 = '0; mv_d1 = 1'b0; mv_d2 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step("mult", 1'b1, 1'b0, mv_d2, mx_d2);
      mx_d2 = mx_d1; mv_d2 = mv_d1;
      mv_d1 = (k < 4);
      mx_d1 = mv_d1 ? 32'((k + 1) * (k + 1)) : 32'd0;
    end
    check("mult.sum30", 64'(bus.acc_out), 64'd30);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: rp = 32'(int'($urandom_range(0, 200)) - 100);
        1: rp = $urandom;
        2: rp = 32'h7FFF_FFFF;
        default: rp = 32'h8000_0000;
      endcase
      if (n == 300) async_reset("rnd_rst");
      step("rnd", ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 4) != 0), rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_accumulator.md
# fir_accumulator

Downstream stage of the FIR filter datapath: consumes the signed products emitted by the two-cycle multiplier `mult_2t` and sums `TAPS` consecutive products into one filter output sample. Uses a wide internal accumulator, arithmetic output scaling and saturation to `DATA_W`, and a sticky overflow flag. The `enable` input matches the stall semantics of the multiplier, so the whole filter pipeline freezes together.

## Interface
- `DATA_W`, 32: width of incoming product and of output sample (two's complement).
- `ACC_W`, 40: internal accumulator width, must be >= `DATA_W`.
- `TAPS`, 8: products per output sample, >= 2.
- `OUT_SHIFT`, 0: arithmetic right shift applied to the final sum before saturation, 0..`ACC_W`-1.

- `clk`  in  1  single clock, all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- `enable`  in  1  1 = run; 0 = stall, all registers hold, inputs ignored.
- `clear`  in  1  synchronous frame abort (qualified by `enable`).
- `prod_in`  in  `DATA_W`  signed product from `mult_2t`.
- `prod_valid`  in  1  `prod_in` carries a product this cycle.
- `acc_out`  out  `DATA_W`  signed filter output sample, registered.
- `acc_valid`  out  1  one-cycle pulse, `acc_out` is new.
- `tap_count`  out  `$clog2(TAPS)`  products accepted in the current frame.
- `overflow`  out  1  sticky: saturation occurred since last reset.

## Operation
- Reset values: `acc_out`=0, `acc_valid`=0, `tap_count`=0, `overflow`=0, accumulator=0.
- Accept condition: `enable`=1 and `prod_valid`=1 at a rising edge. No backpressure; every accepted product is consumed.
- States, implicit in `tap_count`: ACCUM (0..`TAPS`-2) and LAST (`TAPS`-1).
- In ACCUM: accumulator <= accumulator + sign-extended `prod_in`; `tap_count` increments.
- In LAST: sum = accumulator + `prod_in`; `acc_out` <= sat(sum >>> `OUT_SHIFT`); `acc_valid` <= 1; accumulator <= 0; `tap_count` <= 0.
- Accumulator overflow: if an addition exceeds the signed `ACC_W` range, the accumulator clamps to +max/-min of `ACC_W` and `overflow` is set.
- Output saturation: a shifted sum above 2^(`DATA_W`-1)-1 gives 0x7FF..F. A shifted sum below -2^(`DATA_W`-1) gives 0x800..0. Either case sets `overflow`.
- `overflow` clears only on `reset`.
- `clear` (with `enable`=1): accumulator <= 0 and `tap_count` <= 0. A product presented in the same cycle is discarded; `clear` wins. `acc_out` and `overflow` are kept, and `acc_valid` is 0.
- `enable`=0: every register holds, including `acc_out`. `acc_valid` is forced to 0 on the next edge; a pulse is never repeated or stretched. `prod_valid` and `clear` are ignored.
- `prod_valid`=0 with `enable`=1: state holds and `acc_valid` goes to 0.

## Timing
- Latency: `acc_out` and `acc_valid` update on the same edge that accepts the `TAPS`-th product, so they are visible one cycle after that product is presented. Pipeline from the multiplier input to the filter output is 2 + 1 cycles.
- Back-to-back frames at one product per cycle: `acc_valid` pulses every `TAPS` cycles, and no bubble is needed between frames.
- `acc_valid` is high for exactly one cycle per completed frame.
- `reset` asserted mid-frame drops the partial sum. The first accepted product after release starts a new frame.
- `tap_count` wrap: `TAPS`-1 goes to 0 only on acceptance in LAST.
- Critical path: `ACC_W` adder plus clamp mux; the shift and saturate is computed from the adder output in the same cycle.

## Test plan
Default parameters for these scenarios: TAPS=4, DATA_W=32, ACC_W=40, OUT_SHIFT=0.
- Hold `reset`=0 for 3 cycles with random inputs -> all outputs 0. Assert `reset`=0 asynchronously between edges -> outputs 0 before the next edge.
- Products 1,2,3,4 on consecutive cycles -> `acc_out`=10 with a one-cycle `acc_valid`, `tap_count` sequence 1,2,3,0. Continue with 5,6,7,8 -> next `acc_out`=26 exactly 4 cycles later.
- Products 5, idle (`prod_valid`=0), 5, then `enable`=0 for 2 cycles with `prod_valid`=1 and `prod_in`=100, then 5,5 -> `acc_out`=20. Stalled values are not accumulated and there is no spurious `acc_valid`.
- Products -3,-3,-3,-3 -> `acc_out`=0xFFFFFFF4, `overflow`=0.
- Four products of 0x7FFFFFFF -> `acc_out`=0x7FFFFFFF and `overflow`=1. Next frame 1,1,1,1 -> `acc_out`=4 with `overflow` still 1.
- After products 9,9: pulse `clear` together with `prod_valid`=1 and `prod_in`=50, then 1,1,1,1 -> `acc_out`=4. Repeat the abort using `reset` mid-frame -> same result.
- Integrated with `mult_2t`: feed x = 1,2,3,4 to both multiplier inputs, with `prod_valid` = multiplier input valid delayed 2 cycles -> `acc_out`=30.
